// File: rtl/mcu.sv
// Main control unit for the multi-cycle RV32I core.
// Sequences each instruction through fetch, decode, execute and the
// load/store wait states, runs the instruction/data memory handshakes,
// drives the PC/IR strobes and counts retired instructions. Illegal
// opcodes and memory timeouts park the core in ST_HALT until reset.
module mcu #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        MCU_CLOCK_50,
    input  logic        MCU_RESET_InLow,
    input  logic        MCU_Run,
    input  logic [6:0]  MCU_Opcode_InBUS,
    input  logic        MCU_Imem_Rsp_Valid,
    input  logic        MCU_Dmem_Req_Ready,
    input  logic        MCU_Dmem_Rsp_Valid,
    output logic [2:0]  MCU_State_OutBUS,
    output logic        MCU_Imem_Req_Valid,
    output logic        MCU_Ir_Load,
    output logic        MCU_Dmem_Req_Valid,
    output logic        MCU_Pc_Write,
    output logic        MCU_Halted,
    output logic [1:0]  MCU_Error_OutBUS,
    output logic [31:0] MCU_Retired_OutBUS
);

    localparam logic [2:0] ST_IDLE       = 3'b000;
    localparam logic [2:0] ST_FETCH      = 3'b001;
    localparam logic [2:0] ST_DECODE     = 3'b010;
    localparam logic [2:0] ST_EXEC       = 3'b011;
    localparam logic [2:0] ST_WAIT_READY = 3'b100;
    localparam logic [2:0] ST_WAIT_VALID = 3'b101;
    localparam logic [2:0] ST_HALT       = 3'b111;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    // Last wait-counter value before a still-idle memory is declared dead.
    localparam logic [15:0] WAIT_LIMIT = 16'(TIMEOUT_CYCLES - 1);

    logic [2:0]  state_q, state_d;
    logic [15:0] waitCnt_q, waitCnt_d;
    logic        lsuDone_q, lsuDone_d;
    logic [31:0] retired_q, retired_d;
    logic [1:0]  error_q, error_d;
    logic        halted_q, halted_d;

    logic opLegal;
    logic opLs;
    logic imemReq;
    logic irLoad;
    logic dmemReq;
    logic pcWrite;

    // Classify the opcode held in the IR as legal and/or load-store.
    always_comb begin
        opLegal = 1'b0;
        opLs    = 1'b0;
        case (MCU_Opcode_InBUS)
            7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
            7'b1100011, 7'b0010011, 7'b0110011: opLegal = 1'b1;
            7'b0000011, 7'b0100011: begin
                opLegal = 1'b1;
                opLs    = 1'b1;
            end
            default: ;
        endcase
    end

    // Next-state, strobe and bookkeeping logic; the wait counter defaults
    // to zero so any state change (or non-waiting state) clears it.
    always_comb begin
        state_d   = state_q;
        waitCnt_d = '0;
        lsuDone_d = lsuDone_q;
        retired_d = retired_q;
        error_d   = error_q;
        imemReq   = 1'b0;
        irLoad    = 1'b0;
        dmemReq   = 1'b0;
        pcWrite   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (MCU_Run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                imemReq = 1'b1;
                if (MCU_Imem_Rsp_Valid) begin
                    irLoad  = 1'b1;
                    state_d = ST_DECODE;
                end else if (waitCnt_q == WAIT_LIMIT) begin
                    state_d = ST_HALT;
                    error_d = ERR_TIMEOUT;
                end else begin
                    waitCnt_d = waitCnt_q + 16'd1;
                end
            end
            ST_DECODE: begin
                if (opLegal) begin
                    state_d   = ST_EXEC;
                    lsuDone_d = 1'b0;
                end else begin
                    state_d = ST_HALT;
                    error_d = ERR_ILLEGAL;
                end
            end
            ST_EXEC: begin
                if (opLs && !lsuDone_q) begin
                    dmemReq = 1'b1;
                    state_d = MCU_Dmem_Req_Ready ? ST_WAIT_VALID : ST_WAIT_READY;
                end else begin
                    pcWrite   = 1'b1;
                    retired_d = retired_q + 32'd1;
                    state_d   = ST_FETCH;
                end
            end
            ST_WAIT_READY: begin
                dmemReq = 1'b1;
                if (MCU_Dmem_Req_Ready) begin
                    state_d = ST_WAIT_VALID;
                end else if (waitCnt_q == WAIT_LIMIT) begin
                    state_d = ST_HALT;
                    error_d = ERR_TIMEOUT;
                end else begin
                    waitCnt_d = waitCnt_q + 16'd1;
                end
            end
            ST_WAIT_VALID: begin
                if (MCU_Dmem_Rsp_Valid) begin
                    lsuDone_d = 1'b1;
                    state_d   = ST_EXEC;
                end else if (waitCnt_q == WAIT_LIMIT) begin
                    state_d = ST_HALT;
                    error_d = ERR_TIMEOUT;
                end else begin
                    waitCnt_d = waitCnt_q + 16'd1;
                end
            end
            ST_HALT: ;
            default: begin
                state_d = ST_HALT;
                error_d = ERR_ILLEGAL;
            end
        endcase
        halted_d = (state_d == ST_HALT);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge MCU_CLOCK_50) begin
        if (!MCU_RESET_InLow) begin
            state_q   <= ST_IDLE;
            waitCnt_q <= '0;
            lsuDone_q <= 1'b0;
            retired_q <= '0;
            error_q   <= ERR_NONE;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            waitCnt_q <= waitCnt_d;
            lsuDone_q <= lsuDone_d;
            retired_q <= retired_d;
            error_q   <= error_d;
            halted_q  <= halted_d;
        end
    end

    assign MCU_State_OutBUS   = state_q;
    assign MCU_Imem_Req_Valid = imemReq;
    assign MCU_Ir_Load        = irLoad;
    assign MCU_Dmem_Req_Valid = dmemReq;
    assign MCU_Pc_Write       = pcWrite;
    assign MCU_Halted         = halted_q;
    assign MCU_Error_OutBUS   = error_q;
    assign MCU_Retired_OutBUS = retired_q;

endmodule

// File: doc/mcu.md
# mcu

Main control unit for the multi-cycle RV32I core. It sequences every instruction through fetch, decode, execute and the load/store wait states, and drives the 3-bit state bus consumed by the instruction decode unit. It also runs the instruction- and data-memory valid/ready handshakes, issues PC/IR load strobes and counts retired instructions. It halts on an illegal opcode or a memory timeout.

## Interface
- TIMEOUT_CYCLES, 16: maximum cycles spent in any memory-wait state before a timeout halt; legal range 1..65535.
- MCU_CLOCK_50  in  1  system clock, rising edge.
- MCU_RESET_InLow  in  1  reset, synchronous, active-low.
- MCU_Run  in  1  start; sampled only in ST_IDLE.
- MCU_Opcode_InBUS  in  7  opcode field of the instruction register (IR[6:0]).
- MCU_Imem_Rsp_Valid  in  1  instruction-memory response valid; the instruction is on the bus in this cycle.
- MCU_Dmem_Req_Ready  in  1  data memory accepts the request.
- MCU_Dmem_Rsp_Valid  in  1  data memory load data or store acknowledge is valid.
- MCU_State_OutBUS  out  3  current state, registered.
- MCU_Imem_Req_Valid  out  1  instruction fetch request.
- MCU_Ir_Load  out  1  IR capture strobe.
- MCU_Dmem_Req_Valid  out  1  data request.
- MCU_Pc_Write  out  1  PC update strobe, one cycle per retired instruction.
- MCU_Halted  out  1  core stopped.
- MCU_Error_OutBUS  out  2  00 none, 01 illegal opcode, 10 timeout.
- MCU_Retired_OutBUS  out  32  retired-instruction counter.

## Operation
- State encodings:
  - ST_IDLE 000
  - ST_FETCH 001
  - ST_DECODE 010
  - ST_EXEC 011
  - ST_WAIT_READY 100
  - ST_WAIT_VALID 101
  - ST_HALT 111
  - 110 is unused; if entered, the next state is ST_HALT with error 01.
- Legal opcodes: 0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011, 0010011, 0110011. LS opcodes are 0000011 and 0100011.
- ST_IDLE: when MCU_Run=1, go to ST_FETCH.
- ST_FETCH:
  - Imem_Req_Valid=1.
  - On Imem_Rsp_Valid: Ir_Load=1 (combinational, same cycle), then go to ST_DECODE.
- ST_DECODE:
  - Illegal opcode: go to ST_HALT with error 01.
  - Legal opcode: go to ST_EXEC and clear the internal lsu_done flag.
- ST_EXEC, non-LS opcode: Pc_Write=1, increment the retire counter, go to ST_FETCH.
- ST_EXEC, LS opcode with lsu_done=0:
  - Dmem_Req_Valid=1.
  - If Dmem_Req_Ready=1 in the same cycle, go to ST_WAIT_VALID; otherwise go to ST_WAIT_READY.
- ST_EXEC, LS opcode with lsu_done=1 (writeback pass):
  - Dmem_Req_Valid=0, Pc_Write=1, increment the retire counter, go to ST_FETCH.
- ST_WAIT_READY: hold Dmem_Req_Valid=1 until Dmem_Req_Ready, then go to ST_WAIT_VALID.
- ST_WAIT_VALID: on Dmem_Rsp_Valid, set lsu_done=1 and return to ST_EXEC. Stores also wait for the acknowledge.
- Timeout:
  - A 16-bit wait counter clears on every state change.
  - It increments each cycle in ST_FETCH, ST_WAIT_READY and ST_WAIT_VALID while the awaited input is low.
  - When the counter equals TIMEOUT_CYCLES-1 and the input is still low, go to ST_HALT with error 10.
- ST_HALT: Halted=1, error code held. Exit only by reset.
- Retire counter wraps modulo 2^32 (FFFFFFFF -> 00000000).

## Timing
- Reset: when MCU_RESET_InLow=0 at a clock edge, the next state is ST_IDLE. This applies in any state, including in the middle of a handshake.
- Values forced by reset:
  - State_OutBUS=000
  - Halted=0
  - Error=00
  - Retired=0
  - wait counter=0
  - lsu_done=0
  - all strobes 0
- Strobes (Imem_Req_Valid, Ir_Load, Dmem_Req_Valid, Pc_Write) are combinational from the registered state, lsu_done and the current-cycle inputs. No strobe is active in ST_IDLE or ST_HALT.
- Minimum instruction latency with zero-wait memories:
  - Non-LS instruction: 3 cycles (FETCH, DECODE, EXEC).
  - LS instruction: 5 cycles (FETCH, DECODE, EXEC, WAIT_VALID, EXEC).
- Handshake rules:
  - Once raised, Dmem_Req_Valid stays high until the Ready cycle.
  - Exactly one data request is issued per LS instruction.
  - A Dmem_Rsp_Valid arriving outside ST_WAIT_VALID is ignored.
- Halted, Error and Retired are registered and update on the edge that enters ST_HALT or ends the commit cycle.

## Test plan
- Reset then Run=1 with a zero-wait memory and three ADDI (0010011) instructions:
  - State sequence 000,001,010,011 repeated.
  - Pc_Write high in cycles 4, 7 and 10 after reset release.
  - Retired=3.
- LW (0000011) with Dmem_Req_Ready delayed 2 cycles and Rsp_Valid delayed 3 cycles:
  - State sequence 011,100,100,101,101,101,011,001.
  - Dmem_Req_Valid high for exactly 3 cycles.
  - One Pc_Write.
- Opcode 1111111 captured in the IR: ST_DECODE -> ST_HALT, Error=01, Halted=1, no Pc_Write. Still halted with Run toggled for 20 cycles.
- TIMEOUT_CYCLES=4 and Imem_Rsp_Valid never asserted: after 4 cycles in ST_FETCH, state=111 and Error=10.
- Reset asserted while in ST_WAIT_READY: next cycle State=000 and Dmem_Req_Valid=0. A following Run restarts in ST_FETCH.
- Retire counter preloaded (by forcing) to FFFFFFFF, then one ADDI: counter reads 00000000 after commit.
